// File: rtl/tube_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tube_pkg                                                  |
// | Purpose  : Shared types and constants for the Tube parasite bridge.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package tube_pkg;

  localparam int TUBE_ADDR_W = 3;
  localparam int TUBE_DATA_W = 8;

  // Bridge sequencer: one pass through SETUP/STROBE/HOLD per transaction.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } tube_state_e;

  // Parasite-side register map: status/data pairs for FIFOs R1..R4.
  localparam logic [TUBE_ADDR_W-1:0] TUBE_R1_STAT = 3'd0;
  localparam logic [TUBE_ADDR_W-1:0] TUBE_R1_DATA = 3'd1;
  localparam logic [TUBE_ADDR_W-1:0] TUBE_R2_STAT = 3'd2;
  localparam logic [TUBE_ADDR_W-1:0] TUBE_R2_DATA = 3'd3;
  localparam logic [TUBE_ADDR_W-1:0] TUBE_R3_STAT = 3'd4;
  localparam logic [TUBE_ADDR_W-1:0] TUBE_R3_DATA = 3'd5;
  localparam logic [TUBE_ADDR_W-1:0] TUBE_R4_STAT = 3'd6;
  localparam logic [TUBE_ADDR_W-1:0] TUBE_R4_DATA = 3'd7;

  // Largest of three phase lengths; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tube_p_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tube_p_bridge_if                                          |
// | Purpose  : Core-side request bus plus Tube parasite port signals.    |
// |            slave  = the bridge; master = core and Tube ULA side.     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface tube_p_bridge_if;
  import tube_pkg::*;

  // Co-processor side
  logic                   req;
  logic                   we;
  logic [TUBE_ADDR_W-1:0] addr;
  logic [TUBE_DATA_W-1:0] wdata;
  logic [TUBE_DATA_W-1:0] rdata;
  logic                   ack;
  logic                   busy;

  // Tube parasite port
  logic [TUBE_ADDR_W-1:0] p_addr;
  logic                   p_cs_b;
  logic                   p_rd_b;
  logic                   p_wr_b;
  logic [TUBE_DATA_W-1:0] p_data_out;
  logic                   p_data_oe;
  logic [TUBE_DATA_W-1:0] p_data_in;

  // Tube interrupt/reset outputs and their synchronized forms
  logic                   p_irq_b;
  logic                   p_nmi_b;
  logic                   p_rst_b;
  logic                   irq;
  logic                   nmi_pulse;
  logic                   cpu_rst;

  modport slave (
    input  req, we, addr, wdata, p_data_in, p_irq_b, p_nmi_b, p_rst_b,
    output rdata, ack, busy, p_addr, p_cs_b, p_rd_b, p_wr_b,
           p_data_out, p_data_oe, irq, nmi_pulse, cpu_rst
  );

  modport master (
    output req, we, addr, wdata, p_data_in, p_irq_b, p_nmi_b, p_rst_b,
    input  rdata, ack, busy, p_addr, p_cs_b, p_rd_b, p_wr_b,
           p_data_out, p_data_oe, irq, nmi_pulse, cpu_rst
  );
endinterface
`default_nettype wire

// File: rtl/tube_sync2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tube_sync2                                                |
// | Purpose  : Two-flop synchronizer with selectable reset value.        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tube_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic h_rst_b,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge h_rst_b) begin
    if (!h_rst_b) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/tube_p_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tube_p_bridge                                             |
// | Purpose  : Converts single-cycle co-processor requests into timed    |
// |            Tube parasite strobe cycles; synchronizes irq/nmi/rst.    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tube_p_bridge
  import tube_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic           clk,
  input  logic           h_rst_b,
  tube_p_bridge_if.slave bus
);

  localparam int MAX_CYC = max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  // The counter holds "cycles remaining minus one" in the current phase.
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Sequencer
  tube_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   accept;

  // Captured request
  logic                   we_q;
  logic [TUBE_ADDR_W-1:0] addr_q;
  logic [TUBE_DATA_W-1:0] wdata_q;

  // Registered outputs
  logic                   p_cs_b_q, p_cs_b_d;
  logic                   p_rd_b_q, p_rd_b_d;
  logic                   p_wr_b_q, p_wr_b_d;
  logic [TUBE_ADDR_W-1:0] p_addr_q, p_addr_d;
  logic [TUBE_DATA_W-1:0] p_data_out_q, p_data_out_d;
  logic                   p_data_oe_q, p_data_oe_d;
  logic [TUBE_DATA_W-1:0] rdata_q, rdata_d;
  logic                   ack_q, ack_d;
  logic                   busy_q, busy_d;

  // Synchronized Tube outputs
  logic                   irq_sync;
  logic                   nmi_sync;
  logic                   cpu_rst_sync;
  logic                   nmi_dly_q;
  logic                   nmi_pulse_q;

  // ---------------------------------------------------------------------
  // Synchronizers: irq/cpu_rst are inverted before capture so the flop
  // outputs are the active-high levels directly; cpu_rst resets asserted.
  // ---------------------------------------------------------------------
  tube_sync2 #(.RST_VAL(1'b0)) u_sync_irq (
    .clk     (clk),
    .h_rst_b (h_rst_b),
    .d_i     (~bus.p_irq_b),
    .q_o     (irq_sync)
  );

  tube_sync2 #(.RST_VAL(1'b1)) u_sync_nmi (
    .clk     (clk),
    .h_rst_b (h_rst_b),
    .d_i     (bus.p_nmi_b),
    .q_o     (nmi_sync)
  );

  tube_sync2 #(.RST_VAL(1'b1)) u_sync_rst (
    .clk     (clk),
    .h_rst_b (h_rst_b),
    .d_i     (~bus.p_rst_b),
    .q_o     (cpu_rst_sync)
  );

  // NMI edge detector: pulse once per synchronized high-to-low transition.
  always_ff @(posedge clk or negedge h_rst_b) begin
    if (!h_rst_b) begin
      nmi_dly_q   <= 1'b1;
      nmi_pulse_q <= 1'b0;
    end else begin
      nmi_dly_q   <= nmi_sync;
      nmi_pulse_q <= nmi_dly_q & ~nmi_sync;
    end
  end

  // ---------------------------------------------------------------------
  // Sequencer. A request is only taken in IDLE and while the core is not
  // held in reset; once started, a transaction always runs to completion
  // so the Tube never sees a truncated strobe.
  // ---------------------------------------------------------------------

  // State and phase-counter register.
  always_ff @(posedge clk or negedge h_rst_b) begin
    if (!h_rst_b) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: counter reloads on each phase entry and counts down to 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req && !cpu_rst_sync) begin
          accept  = 1'b1;
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Request capture: the core's bus is only looked at in the accept cycle.
  always_ff @(posedge clk or negedge h_rst_b) begin
    if (!h_rst_b) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= bus.we;
      addr_q  <= bus.addr;
      wdata_q <= bus.wdata;
    end
  end

  // ---------------------------------------------------------------------
  // Output decode. Outputs are registered from the current state, so the
  // pins trail the sequencer by one cycle; this is what places p_cs_b one
  // edge after the accepting edge and lets a new request be accepted on
  // the edge where ack falls.
  // ---------------------------------------------------------------------

  // Pin and status values for the next cycle.
  always_comb begin
    p_cs_b_d     = (state_q == ST_IDLE);
    p_rd_b_d     = !((state_q == ST_STROBE) && !we_q);
    p_wr_b_d     = !((state_q == ST_STROBE) && we_q);
    p_data_oe_d  = (state_q != ST_IDLE) && we_q;
    p_addr_d     = p_addr_q;
    p_data_out_d = p_data_out_q;
    if (state_q != ST_IDLE) begin
      p_addr_d = addr_q;
      if (we_q) begin
        p_data_out_d = wdata_q;
      end
    end
    ack_d   = (state_q == ST_HOLD) && (cnt_q == '0);
    busy_d  = (state_q != ST_IDLE) || accept;
    // Sample on the edge that raises p_rd_b: the Tube FIFO pops on that
    // rising edge, so the data must be taken from the last low cycle.
    rdata_d = rdata_q;
    if (!p_rd_b_q && p_rd_b_d) begin
      rdata_d = bus.p_data_in;
    end
  end

  // Output register bank; reset leaves every strobe deasserted.
  always_ff @(posedge clk or negedge h_rst_b) begin
    if (!h_rst_b) begin
      p_cs_b_q     <= 1'b1;
      p_rd_b_q     <= 1'b1;
      p_wr_b_q     <= 1'b1;
      p_addr_q     <= '0;
      p_data_out_q <= '0;
      p_data_oe_q  <= 1'b0;
      rdata_q      <= '0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      p_cs_b_q     <= p_cs_b_d;
      p_rd_b_q     <= p_rd_b_d;
      p_wr_b_q     <= p_wr_b_d;
      p_addr_q     <= p_addr_d;
      p_data_out_q <= p_data_out_d;
      p_data_oe_q  <= p_data_oe_d;
      rdata_q      <= rdata_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.p_cs_b     = p_cs_b_q;
  assign bus.p_rd_b     = p_rd_b_q;
  assign bus.p_wr_b     = p_wr_b_q;
  assign bus.p_addr     = p_addr_q;
  assign bus.p_data_out = p_data_out_q;
  assign bus.p_data_oe  = p_data_oe_q;
  assign bus.rdata      = rdata_q;
  assign bus.ack        = ack_q;
  assign bus.busy       = busy_q;
  assign bus.irq        = irq_sync;
  assign bus.nmi_pulse  = nmi_pulse_q;
  assign bus.cpu_rst    = cpu_rst_sync;

endmodule
`default_nettype wire

// File: doc/tube_p_bridge.md
# tube_p_bridge

Parasite-side bus bridge that converts a synchronous co-processor bus (`clk`, single-cycle request) into the asynchronous Tube parasite strobe interface (`p_cs_b`, `p_rd_b`, `p_wr_b`, `p_addr`, split `p_data`). It sits directly between the soft co-processor core and the Tube ULA parasite port. It sequences setup, strobe and hold phases with programmable cycle counts, captures read data, and brings the Tube's `p_irq_b`, `p_nmi_b` and `p_rst_b` outputs into the `clk` domain.

## Interface
Parameters:
- SETUP_CYC, 1, cycles with `p_cs_b`/`p_addr` valid before strobe asserts (≥1)
- STROBE_CYC, 2, cycles `p_rd_b`/`p_wr_b` held low (≥1)
- HOLD_CYC, 1, cycles `p_cs_b`/`p_addr`/write data held after strobe deasserts (≥1)

Ports:
- clk  in  1  co-processor clock
- h_rst_b  in  1  reset, asynchronous, active-low
- req  in  1  single-cycle transaction request, sampled only in IDLE
- we  in  1  1 = write, 0 = read; sampled with req
- addr  in  3  Tube register address; sampled with req
- wdata  in  8  write data; sampled with req
- rdata  out  8  read data, valid in the ack cycle, held until the next read completes
- ack  out  1  one-cycle completion pulse
- busy  out  1  high from the cycle after an accepted req until the ack cycle inclusive
- p_addr  out  3  Tube parasite address
- p_cs_b  out  1  Tube chip select, active-low
- p_rd_b  out  1  read strobe, active-low
- p_wr_b  out  1  write strobe, active-low
- p_data_out  out  8  write data to Tube
- p_data_oe  out  1  write data valid / drive enable
- p_data_in  in  8  read data from Tube
- p_irq_b, p_nmi_b, p_rst_b  in  1 each  Tube interrupt and reset outputs (asynchronous)
- irq  out  1  synchronized, active-high level of `!p_irq_b`
- nmi_pulse  out  1  one-cycle pulse on a synchronized falling edge of `p_nmi_b`
- cpu_rst  out  1  synchronized, active-high level of `!p_rst_b`

## Operation
- FSM states: IDLE → SETUP → STROBE → HOLD → IDLE. A down-counter loads on each state entry.
- IDLE: accept `req` when `cpu_rst` = 0. Register `we`, `addr` and `wdata`. Go to SETUP.
- SETUP (SETUP_CYC cycles): `p_cs_b` = 0, `p_addr` valid, both strobes high. `p_data_oe` = 1 if the transaction is a write.
- STROBE (STROBE_CYC cycles): `p_rd_b` = 0 for a read, `p_wr_b` = 0 for a write. `p_data_in` is captured into `rdata` on the last STROBE cycle, before the strobe rises, because the Tube FIFO pops on the rising edge of `p_rd_b`.
- HOLD (HOLD_CYC cycles): strobes high, `p_cs_b` = 0, address and write data held. `ack` pulses on the last HOLD cycle. The next state is IDLE.
- When `p_cs_b` goes high, `p_data_oe` drops in the same cycle.
- A `req` while busy is ignored, with no queueing.
- A `req` while `cpu_rst` = 1 is ignored.
- If `cpu_rst` asserts during a transaction, the transaction completes normally, including ack. The Tube FIFO state must never see a truncated strobe.
- Only one of `p_rd_b` / `p_wr_b` is ever low at a time. Both are high whenever `p_cs_b` is high.
- Synchronizers: 2-flop for all three inputs. `nmi_pulse` is generated from the synchronized value and its 1-cycle-delayed copy. A sustained low level produces only one pulse.

## Timing
- All outputs are registered on `clk` rising edge.
- Reset values: `p_cs_b`, `p_rd_b`, `p_wr_b` = 1. `p_addr` = 0, `p_data_out` = 0, `p_data_oe` = 0. `rdata` = 0, `ack` = 0, `busy` = 0. `irq` = 0, `nmi_pulse` = 0.
- `cpu_rst` reset value = 1, i.e. the synchronizer flops reset to the "reset asserted" state, so the core stays held until two edges after `p_rst_b` is seen high.
- `req` sampled at edge N: `p_cs_b` low from edge N+1. Strobe low from edge N+1+SETUP_CYC. Strobe high at edge N+1+SETUP_CYC+STROBE_CYC.
- `ack` high in the cycle after edge N+SETUP_CYC+STROBE_CYC+HOLD_CYC. With default parameters this is edge N+4.
- `p_cs_b` returns high on the edge where `ack` falls. The earliest next accepted `req` is at that same edge, giving back-to-back transactions with `p_cs_b` high for at least 1 cycle.
- Interrupt latency: 2 `clk` edges from input change to `irq` / `cpu_rst`. `nmi_pulse` asserts 3 edges after the falling edge of `p_nmi_b`.
- Reset mid-transaction: FSM goes to IDLE immediately, with all strobes high and no ack.

## Structure
- Shared package `tube_pkg`:
  - FSM state enum
  - Tube register address constants (R1..R4 status/data addresses 0..7)
- Sub-module `tube_sync2`: parameterizable reset-value 2-flop synchronizer, instanced ×3.
- Counter width = clog2 of max(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1.

## Test plan
- Write `req`, `we` = 1, `addr` = 1, `wdata` = 0xA5, defaults → `p_cs_b` low 4 cycles. `p_wr_b` low exactly cycles 2–3. `p_data_out` = 0xA5 while `p_data_oe` = 1. `ack` at req edge +4.
- Read `addr` = 5 with `p_data_in` = 0x3C during STROBE, changing to 0xFF after `p_rd_b` rises → `rdata` = 0x3C at ack. `p_rd_b` low 2 cycles. `p_wr_b` never low.
- Back-to-back: `req` pulsed in the ack-clearing cycle → second transaction starts immediately, `p_cs_b` high exactly 1 cycle between. A `req` pulsed mid-transaction is ignored and produces no extra ack.
- SETUP_CYC = 3, STROBE_CYC = 4, HOLD_CYC = 2 → `ack` at +9 cycles, strobe low exactly 4 cycles.
- `p_nmi_b` held low 10 cycles → exactly one `nmi_pulse` 3 edges after the fall. `p_irq_b` low → `irq` = 1 after 2 edges.
- `p_rst_b` low → `cpu_rst` = 1, and a `req` is ignored. Assert `h_rst_b` during STROBE → strobes and `p_cs_b` high immediately, no ack. After release, `busy` = 0.
